board_pixel_fetch: RTL and testbench

Pixel-to-cell scan converter for the Tetris display path. It sits between the VGA timing generator and the playfield board memory. It tracks the active-video raster with internal counters and maps each pixel inside the board window to its board cell using incremental divide-by-CELL_PX counters, with no dividers. It then reads that cell's colour from board memory and emits a pipelined pixel colour stream aligned to a delayed data-enable. It is the inverse of the cell-to-pixel upscaler: pixel coordinate in, cell address out.

---
 rtl/board_pkg.sv | 12 +
 rtl/cell_counter.sv | 48 ++++
 rtl/board_pixel_fetch.sv | 146 ++++++++++++++
 tb/tb_board_pixel_fetch.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// Board geometry and shared types for the playfield display path
// (board RAM, cell-to-pixel upscaler and pixel-to-cell fetch).
package board_pkg;

    localparam int CELL_PX = 20;
    localparam int COLS    = 12;
    localparam int ROWS    = 22;

    typedef logic [3:0] color_t;
    typedef logic [8:0] cell_addr_t;

endpackage

// File: rtl/cell_counter.sv
// Modulo-CELL_PX sub-pixel counter chained into a cell index.
// Clear and enable may coincide (count starts from zero); the pair holds at its last value.
module cell_counter #(
    parameter int CELL_PX = 20,
    parameter int CELLS   = 12,
    parameter int SUB_W   = $clog2(CELL_PX),
    parameter int IDX_W   = $clog2(CELLS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [SUB_W-1:0] sub,
    output logic [IDX_W-1:0] idx
);

    localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(CELL_PX - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(CELLS - 1);

    logic [SUB_W-1:0] sub_base, sub_nxt;
    logic [IDX_W-1:0] idx_base, idx_nxt;

    always_comb begin
        sub_base = clr ? '0 : sub;
        idx_base = clr ? '0 : idx;
        sub_nxt  = sub_base;
        idx_nxt  = idx_base;
        if (en && !((sub_base == SUB_MAX) && (idx_base == IDX_MAX))) begin
            if (sub_base == SUB_MAX) begin
                sub_nxt = '0;
                idx_nxt = idx_base + IDX_W'(1);
            end else begin
                sub_nxt = sub_base + SUB_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub <= '0;
            idx <= '0;
        end else begin
            sub <= sub_nxt;
            idx <= idx_nxt;
        end
    end

endmodule

// File: rtl/board_pixel_fetch.sv
// Raster-to-cell scan converter: tracks the active-video position, reads the
// covering board cell from synchronous RAM and emits colour two cycles after de.
module board_pixel_fetch
    import board_pkg::*;
#(
    parameter int     CELL_PX    = board_pkg::CELL_PX,
    parameter int     COLS       = board_pkg::COLS,
    parameter int     ROWS       = board_pkg::ROWS,
    parameter int     X0         = 200,
    parameter int     Y0         = 20,
    parameter color_t BG_COLOR   = 4'h0,
    parameter bit     GRID_EN    = 1'b1,
    parameter color_t GRID_COLOR = 4'h8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_start,
    input  logic       de,
    output cell_addr_t rd_addr,
    output logic       rd_en,
    input  color_t     rd_data,
    output logic       pix_de,
    output color_t     pix_color
);

    localparam int SUB_W = $clog2(CELL_PX);
    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS);

    localparam logic [9:0] X_LO = 10'(X0);
    localparam logic [9:0] X_HI = 10'(X0 + COLS * CELL_PX);
    localparam logic [9:0] Y_LO = 10'(Y0);
    localparam logic [9:0] Y_HI = 10'(Y0 + ROWS * CELL_PX);

    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

    logic [9:0]       x_q, y_q, x_cur, y_cur;
    logic             de_q, line_end, in_x, in_y, line_win, win, grid;
    logic [SUB_W-1:0] sub_x_q, sub_y_q, sub_x, sub_y;
    logic [COL_W-1:0] cell_col_q, cell_col;
    logic [ROW_W-1:0] cell_row_q, cell_row;
    cell_addr_t       addr;

    logic             vld_p0, win_p0, grid_p0;
    logic             vld_p1, win_p1, grid_p1;

    // A frame_start pixel is position (0,0) regardless of the stale counters.
    always_comb begin
        line_end = de_q & ~de & ~frame_start;
        x_cur    = frame_start ? '0 : x_q;
        y_cur    = frame_start ? '0 : y_q;
        in_x     = (x_cur >= X_LO) && (x_cur < X_HI);
        in_y     = (y_cur >= Y_LO) && (y_cur < Y_HI);
        win      = de & in_x & in_y;
        line_win = (y_q >= Y_LO) && (y_q < Y_HI);
        sub_x    = frame_start ? '0 : sub_x_q;
        sub_y    = frame_start ? '0 : sub_y_q;
        cell_col = frame_start ? '0 : cell_col_q;
        cell_row = frame_start ? '0 : cell_row_q;
        // cell_row * 12 as a shift-add; the board is always 12 cells wide
        addr     = cell_addr_t'({cell_row, 3'b000}) + cell_addr_t'({cell_row, 2'b00})
                 + cell_addr_t'(cell_col);
        grid     = GRID_EN && ((sub_x == '0) || (sub_y == '0));
    end

    cell_counter #(
        .CELL_PX (CELL_PX),
        .CELLS   (COLS),
        .SUB_W   (SUB_W),
        .IDX_W   (COL_W)
    ) u_h_count (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (frame_start | line_end),
        .en    (win),
        .sub   (sub_x_q),
        .idx   (cell_col_q)
    );

    cell_counter #(
        .CELL_PX (CELL_PX),
        .CELLS   (ROWS),
        .SUB_W   (SUB_W),
        .IDX_W   (ROW_W)
    ) u_v_count (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (frame_start),
        .en    (line_end & line_win),
        .sub   (sub_y_q),
        .idx   (cell_row_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q  <= '0;
            y_q  <= '0;
            de_q <= 1'b0;
        end else begin
            de_q <= de;
            if (frame_start) begin
                x_q <= de ? 10'd1 : 10'd0;
                y_q <= '0;
            end else if (de) begin
                x_q <= sat_inc(x_q);
            end else if (de_q) begin
                x_q <= '0;
                y_q <= sat_inc(y_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            vld_p0    <= 1'b0;
            win_p0    <= 1'b0;
            grid_p0   <= 1'b0;
            vld_p1    <= 1'b0;
            win_p1    <= 1'b0;
            grid_p1   <= 1'b0;
            pix_de    <= 1'b0;
            pix_color <= '0;
        end else begin
            // p0: RAM address issued
            rd_en     <= win;
            rd_addr   <= win ? addr : '0;
            vld_p0    <= de;
            win_p0    <= win;
            grid_p0   <= grid;
            // p1: RAM data in flight
            vld_p1    <= vld_p0;
            win_p1    <= win_p0;
            grid_p1   <= grid_p0;
            // p2: colour select
            pix_de    <= vld_p1;
            if (!win_p1)      pix_color <= BG_COLOR;
            else if (grid_p1) pix_color <= GRID_COLOR;
            else              pix_color <= rd_data;
        end
    end

endmodule

// File: tb/tb_board_pixel_fetch.sv
// Directed raster bench for board_pixel_fetch with a queue-based scoreboard.
module tb_board_pixel_fetch;

    localparam int         X0   = 200;
    localparam int         Y0   = 20;
    localparam logic [3:0] BG   = 4'h0;
    localparam logic [3:0] GRID = 4'h8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_start = 1'b0;
    logic       de = 1'b0;
    logic [8:0] rd_addr;
    logic       rd_en;
    logic [3:0] rd_data = 4'h0;
    logic       pix_de;
    logic [3:0] pix_color;

    always #5 clk = ~clk;

    board_pixel_fetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .de          (de),
        .rd_addr     (rd_addr),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .pix_de      (pix_de),
        .pix_color   (pix_color)
    );

    logic [3:0] mem [0:263];
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int issue; logic [3:0] color; } pix_t;
    typedef struct { int issue; logic en; int addr; } rd_t;
    pix_t pixq[$];
    rd_t  rdq[$];
    pix_t p;
    rd_t  r;

    int n_cmp = 0;
    int n_bad = 0;
    int mx = 0;
    int my = 0;
    logic prev_d = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d, line %0d)", name, act, exp, cyc, my);
        end
    endtask

    function automatic void model(input int x, input int y, output logic en,
                                  output int addr, output logic [3:0] col);
        int dx, dy;
        en = 1'b0; addr = 0; col = BG;
        if (x >= X0 && x < X0 + 240 && y >= Y0 && y < Y0 + 440) begin
            dx   = x - X0;
            dy   = y - Y0;
            en   = 1'b1;
            addr = (dy / 20) * 12 + dx / 20;
            col  = ((dx % 20) == 0 || (dy % 20) == 0) ? GRID : mem[addr];
        end
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (rdq.size() > 0 && rdq[0].issue == cyc) begin
                r = rdq.pop_front();
                check("rd_en", int'(rd_en), int'(r.en));
                if (r.en) check("rd_addr", int'(rd_addr), r.addr);
            end else if (rd_en) begin
                check("rd_en_without_de", int'(rd_en), 0);
            end
            if (pix_de) begin
                if (pixq.size() == 0) begin
                    check("pix_de_extra", int'(pix_de), 0);
                end else begin
                    p = pixq.pop_front();
                    check("pix_color", int'(pix_color), int'(p.color));
                    check("pix_latency", cyc - p.issue, 2);
                end
            end else if (pixq.size() > 0 && cyc > pixq[0].issue + 2) begin
                void'(pixq.pop_front());
                check("pix_de_missing", int'(pix_de), 1);
            end
        end
    end

    task automatic step_h(input logic fs, input logic d, input bit hand,
                          input logic h_en, input int h_addr, input logic [3:0] h_col);
        logic en;
        int addr;
        logic [3:0] col;
        @(negedge clk);
        #1;
        frame_start = fs;
        de = d;
        if (fs) begin
            mx = 0;
            my = 0;
        end
        if (d) begin
            if (hand) begin
                en = h_en; addr = h_addr; col = h_col;
            end else begin
                model(mx, my, en, addr, col);
            end
            rdq.push_back('{issue: cyc + 1, en: en, addr: addr});
            pixq.push_back('{issue: cyc + 1, color: col});
            mx++;
        end else if (prev_d && !fs) begin
            mx = 0;
            my++;
        end
        prev_d = d;
    endtask

    task automatic step(input logic fs, input logic d);
        step_h(fs, d, 1'b0, 1'b0, 0, 4'h0);
    endtask

    task automatic pixels(input int n);
        repeat (n) step(1'b0, 1'b1);
    endtask

    task automatic hand_pixel(input logic en, input int addr, input logic [3:0] col);
        step_h(1'b0, 1'b1, 1'b1, en, addr, col);
    endtask

    task automatic end_line();
        step(1'b0, 1'b0);
    endtask

    task automatic short_lines_to(input int target);
        while (my < target) begin
            step(1'b0, 1'b1);
            end_line();
        end
    endtask

    initial begin
        for (int i = 0; i < 264; i++) mem[i] = 4'((i * 3 + 1) % 16);
        mem[0]   = 4'hA;
        mem[25]  = 4'h3;
        mem[263] = 4'hC;

        repeat (2) @(negedge clk);
        #1;
        check("reset_pix_de", int'(pix_de), 0);
        check("reset_pix_color", int'(pix_color), 0);
        check("reset_rd_en", int'(rd_en), 0);
        check("reset_rd_addr", int'(rd_addr), 0);
        rst_n = 1'b1;

        step(1'b1, 1'b0);
        pixels(640);
        end_line();

        // grid column and first plain pixel of cell (row 0, col 1); window right edge
        short_lines_to(Y0 + 5);
        pixels(X0 + 20);
        hand_pixel(1'b1, 1, GRID);
        hand_pixel(1'b1, 1, 4'h4);
        pixels(218);
        hand_pixel(1'b0, 0, BG);
        end_line();

        short_lines_to(Y0 + 45);
        pixels(X0 + 25);
        hand_pixel(1'b1, 25, 4'h3);
        pixels(5);
        end_line();

        // last cell of the board, then first pixel past the window
        short_lines_to(Y0 + 439);
        pixels(X0 + 239);
        hand_pixel(1'b1, 263, 4'hC);
        hand_pixel(1'b0, 0, BG);
        end_line();
        pixels(450);
        end_line();

        // frame_start arriving mid-line with de high
        pixels(10);
        step(1'b1, 1'b1);
        pixels(4);
        end_line();
        short_lines_to(Y0);
        pixels(X0);
        hand_pixel(1'b1, 0, GRID);
        end_line();

        // asynchronous reset in the middle of a window line
        pixels(X0 + 5);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        de = 1'b0;
        #1;
        check("midline_reset_pix_de", int'(pix_de), 0);
        check("midline_reset_pix_color", int'(pix_color), 0);
        check("midline_reset_rd_en", int'(rd_en), 0);
        pixq.delete();
        rdq.delete();
        prev_d = 1'b0;
        mx = 0;
        my = 0;
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;

        step(1'b1, 1'b0);
        short_lines_to(Y0);
        pixels(X0);
        hand_pixel(1'b1, 0, GRID);
        pixels(3);
        end_line();

        repeat (6) step(1'b0, 1'b0);
        check("pix_queue_drained", pixq.size(), 0);
        check("rd_queue_drained", rdq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
